// File: rtl/tg_pkg.sv
// Shared types and constants for the TG pulse generator.
// Phase enum plus the next-nonzero-phase selector.
package tg_pkg;

   localparam int TG_W_WIDTH = 4;
   localparam int TG_W_SEQ   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      P1   = 2'd1,
      P2   = 2'd2,
      P3   = 2'd3
   } tg_state_e;

   // Phases with a zero width are skipped; IDLE means the sequence is over.
   function automatic tg_state_e next_phase(
      input tg_state_e cur,
      input logic      nz1,
      input logic      nz2,
      input logic      nz3
   );
      tg_state_e nxt;
      nxt = IDLE;
      unique case (cur)
         IDLE: begin
            if (nz1)
               nxt = P1;
            else if (nz2)
               nxt = P2;
            else if (nz3)
               nxt = P3;
         end
         P1: begin
            if (nz2)
               nxt = P2;
            else if (nz3)
               nxt = P3;
         end
         P2: begin
            if (nz3)
               nxt = P3;
         end
         default: nxt = IDLE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/tg_width_cnt.sv
// Loadable down-counter that times one pulse phase.
// Holds at zero until reloaded.
module tg_width_cnt
   import tg_pkg::*;
#(
   parameter int W = TG_W_WIDTH
) (
   input  logic         clk,
   input  logic         C_purstb,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge C_purstb) begin
      if (!C_purstb)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/tg_pulse_gen.sv
// TG pulse source: three contiguous programmable pulses per start,
// with a wrapping count of completed sequences.
module tg_pulse_gen
   import tg_pkg::*;
#(
   parameter int W_WIDTH = TG_W_WIDTH,
   parameter int W_SEQ   = TG_W_SEQ
) (
   input  logic               clk,
   input  logic               C_purstb,
   input  logic               start,
   input  logic [W_WIDTH-1:0] B_test1,
   input  logic [W_WIDTH-1:0] B_test2,
   input  logic [W_WIDTH-1:0] B_test3,
   output logic               DA_test1,
   output logic               DA_test2,
   output logic               DA_test3,
   output logic [W_SEQ-1:0]   DA_test4,
   output logic               busy,
   output logic               done
);

   tg_state_e          state;
   tg_state_e          nxt;
   logic [W_WIDTH-1:0] sh1;
   logic [W_WIDTH-1:0] sh2;
   logic [W_WIDTH-1:0] sh3;
   logic [W_WIDTH-1:0] src1;
   logic [W_WIDTH-1:0] src2;
   logic [W_WIDTH-1:0] src3;
   logic [W_WIDTH-1:0] wsel;
   logic [W_WIDTH-1:0] ld_val;
   logic               ld;
   logic               launch;
   logic               seq_end;
   logic               cnt_zero;

   // At launch the shadows are not yet written, so widths come straight
   // from the inputs; afterwards only the shadowed copies are used.
   always_comb begin
      src1    = (state == IDLE) ? B_test1 : sh1;
      src2    = (state == IDLE) ? B_test2 : sh2;
      src3    = (state == IDLE) ? B_test3 : sh3;
      launch  = (state == IDLE) && start;
      nxt     = state;
      seq_end = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               nxt     = next_phase(IDLE, |src1, |src2, |src3);
               seq_end = (nxt == IDLE);
            end
         end
         default: begin
            if (cnt_zero) begin
               nxt     = next_phase(state, |src1, |src2, |src3);
               seq_end = (nxt == IDLE);
            end
         end
      endcase
   end

   always_comb begin
      wsel = '0;
      unique case (nxt)
         P1:      wsel = src1;
         P2:      wsel = src2;
         P3:      wsel = src3;
         default: wsel = '0;
      endcase
      ld     = (nxt != IDLE) && (nxt != state);
      ld_val = ld ? (wsel - W_WIDTH'(1)) : '0;
   end

   tg_width_cnt #(
      .W (W_WIDTH)
   ) u_cnt (
      .clk      (clk),
      .C_purstb (C_purstb),
      .load     (ld),
      .load_val (ld_val),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge C_purstb) begin
      if (!C_purstb) begin
         state    <= IDLE;
         sh1      <= '0;
         sh2      <= '0;
         sh3      <= '0;
         DA_test1 <= 1'b0;
         DA_test2 <= 1'b0;
         DA_test3 <= 1'b0;
         DA_test4 <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= nxt;
         DA_test1 <= (nxt == P1);
         DA_test2 <= (nxt == P2);
         DA_test3 <= (nxt == P3);
         busy     <= (nxt != IDLE);
         done     <= seq_end;
         if (seq_end)
            DA_test4 <= DA_test4 + W_SEQ'(1);
         if (launch) begin
            sh1 <= B_test1;
            sh2 <= B_test2;
            sh3 <= B_test3;
         end
      end
   end

endmodule

// File: tb/tb_tg_pulse_gen.sv
// Bench for tg_pulse_gen: schedule-based model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_tg_pulse_gen;

   typedef struct packed {
      logic       d1;
      logic       d2;
      logic       d3;
      logic       busy;
      logic       done;
      logic [3:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] b1 = '0;
   logic [3:0] b2 = '0;
   logic [3:0] b3 = '0;
   logic       da1;
   logic       da2;
   logic       da3;
   logic [3:0] da4;
   logic       busy;
   logic       done;

   int n_tests = 0;
   int n_fail  = 0;
   logic chk_en = 1'b0;

   exp_t       q[$];
   exp_t       cur = '0;
   logic [3:0] mcnt = '0;

   tg_pulse_gen #(
      .W_WIDTH (4),
      .W_SEQ   (4)
   ) dut (
      .clk      (clk),
      .C_purstb (rst_n),
      .start    (start),
      .B_test1  (b1),
      .B_test2  (b2),
      .B_test3  (b3),
      .DA_test1 (da1),
      .DA_test2 (da2),
      .DA_test3 (da3),
      .DA_test4 (da4),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Model: on an accepted start, lay out the whole expected waveform.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         mcnt = '0;
         cur  = '0;
      end else begin
         if (!cur.busy && start) begin
            for (int n = 0; n < 3; n++) begin
               int w;
               exp_t e;
               w = (n == 0) ? int'(b1) : (n == 1) ? int'(b2) : int'(b3);
               e = '0;
               e.d1   = (n == 0);
               e.d2   = (n == 1);
               e.d3   = (n == 2);
               e.busy = 1'b1;
               e.cnt  = mcnt;
               for (int i = 0; i < w; i++)
                  q.push_back(e);
            end
            mcnt = mcnt + 4'd1;
            begin
               exp_t e;
               e      = '0;
               e.done = 1'b1;
               e.cnt  = mcnt;
               q.push_back(e);
            end
         end
         if (q.size() > 0) begin
            cur = q.pop_front();
         end else begin
            cur     = '0;
            cur.cnt = mcnt;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         exp_t act;
         act = {da1, da2, da3, busy, done, da4};
         n_tests++;
         if (act !== cur) begin
            n_fail++;
            $display("FAIL cycle t=%0t: got %b required %b", $time, act, cur);
         end
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_seq(
      input  logic [3:0] w1,
      input  logic [3:0] w2,
      input  logic [3:0] w3,
      input  int         nsamp,
      input  int         chg_at,
      input  int         restart_at,
      output int         h1,
      output int         h2,
      output int         h3,
      output int         hb,
      output int         dat
   );
      b1 = w1;
      b2 = w2;
      b3 = w3;
      start = 1'b1;
      h1 = 0;
      h2 = 0;
      h3 = 0;
      hb = 0;
      dat = -1;
      for (int k = 0; k < nsamp; k++) begin
         @(negedge clk);
         h1 += int'(da1);
         h2 += int'(da2);
         h3 += int'(da3);
         hb += int'(busy);
         if (done && dat < 0)
            dat = k;
         start = (k == restart_at);
         if (k == chg_at) begin
            b1 = 4'd2;
            b2 = 4'd2;
            b3 = 4'd2;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      int h1, h2, h3, hb, dat, dones, saw15;

      repeat (2) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_cnt", int'(da4), 0);
      check("rst_pulses", int'({da1, da2, da3}), 0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      run_seq(4'd3, 4'd5, 4'd2, 14, -1, -1, h1, h2, h3, hb, dat);
      check("t1_w1", h1, 3);
      check("t1_w2", h2, 5);
      check("t1_w3", h3, 2);
      check("t1_busy", hb, 10);
      check("t1_done_at", dat, 10);
      check("t1_cnt", int'(da4), 1);

      run_seq(4'd0, 4'd4, 4'd0, 8, -1, -1, h1, h2, h3, hb, dat);
      check("t2_w1", h1, 0);
      check("t2_w2", h2, 4);
      check("t2_w3", h3, 0);
      check("t2_done_at", dat, 4);
      check("t2_cnt", int'(da4), 2);

      run_seq(4'd0, 4'd0, 4'd0, 4, -1, -1, h1, h2, h3, hb, dat);
      check("t6_pulses", h1 + h2 + h3, 0);
      check("t6_busy", hb, 0);
      check("t6_done_at", dat, 0);
      check("t6_cnt", int'(da4), 3);

      run_seq(4'd15, 4'd15, 4'd15, 50, 5, 20, h1, h2, h3, hb, dat);
      check("t4_w1", h1, 15);
      check("t4_w2", h2, 15);
      check("t4_w3", h3, 15);
      check("t4_busy", hb, 45);
      check("t4_done_at", dat, 45);
      check("t4_cnt", int'(da4), 4);

      do_reset();
      b1 = 4'd1;
      b2 = 4'd1;
      b3 = 4'd1;
      start = 1'b1;
      dones = 0;
      saw15 = 0;
      repeat (64) begin
         @(negedge clk);
         if (done)
            dones++;
         if (da4 == 4'd15)
            saw15 = 1;
      end
      start = 1'b0;
      check("t3_dones", dones, 16);
      check("t3_saw15", saw15, 1);
      check("t3_wrap", int'(da4), 0);

      repeat (2) @(negedge clk);
      b1 = 4'd2;
      b2 = 4'd3;
      b3 = 4'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_in_p2", int'(da2), 1);
      #1 rst_n = 1'b0;
      #1;
      check("t5_async_p2", int'(da2), 0);
      check("t5_async_busy", int'(busy), 0);
      check("t5_async_cnt", int'(da4), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (6) begin
         @(negedge clk);
         if (done)
            dones++;
      end
      check("t5_no_done", dones, 0);
      check("t5_idle", int'(busy), 0);
      check("t5_cnt", int'(da4), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
